// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with transaction watchdog
//
// Shares one slave bus between master 0 (CPU) and master 1 (DMA / debug loader).
// A grant is held until the slave acknowledges, or until the watchdog expires.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   m_req/m_wen           per-master request and write enable (bit i = master i)
//   m_mode/m_num/m_addr   per-master access mode, slave number, offset address
//   m_dat_w               per-master write data
//   m_dat_r, m_ready      read data and one-cycle completion pulse back to masters
//   bus_*                 shared slave-side request fields
//   bus_dat_i, bus_ready  slave read data and completion pulse
//   grant                 one-hot current owner, 0 while idle
//   timeout_err           sticky watchdog flag
module bus_arbiter #(
    parameter int              XLEN        = 32,
    parameter int              SLAVE_WIDTH = 4,
    parameter int              TIMEOUT     = 256,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      m_req,
    input  logic [1:0]                      m_wen,
    input  logic [5:0]                      m_mode,
    input  logic [2*SLAVE_WIDTH-1:0]        m_num,
    input  logic [2*(XLEN-SLAVE_WIDTH)-1:0] m_addr,
    input  logic [2*XLEN-1:0]               m_dat_w,
    output logic [XLEN-1:0]                 m_dat_r,
    output logic [1:0]                      m_ready,
    output logic                            bus_req,
    output logic                            bus_wen,
    output logic [2:0]                      bus_mode,
    output logic [SLAVE_WIDTH-1:0]          bus_num,
    output logic [XLEN-SLAVE_WIDTH-1:0]     bus_addr,
    output logic [XLEN-1:0]                 bus_dat_o,
    input  logic [XLEN-1:0]                 bus_dat_i,
    input  logic                            bus_ready,
    output logic [1:0]                      grant,
    output logic                            timeout_err
);

    localparam int AW = XLEN - SLAVE_WIDTH;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          own_req;
    logic          own_wen;
    logic [2:0]    own_mode;
    logic [SLAVE_WIDTH-1:0] own_num;
    logic [AW-1:0] own_addr;
    logic [XLEN-1:0] own_dat;
    logic [1:0]    own_onehot;

    always_comb begin
        own_req    = owner_q ? m_req[1]                 : m_req[0];
        own_wen    = owner_q ? m_wen[1]                 : m_wen[0];
        own_mode   = owner_q ? m_mode[5:3]              : m_mode[2:0];
        own_num    = owner_q ? m_num[2*SLAVE_WIDTH-1:SLAVE_WIDTH] : m_num[SLAVE_WIDTH-1:0];
        own_addr   = owner_q ? m_addr[2*AW-1:AW]        : m_addr[AW-1:0];
        own_dat    = owner_q ? m_dat_w[2*XLEN-1:XLEN]   : m_dat_w[XLEN-1:0];
        own_onehot = owner_q ? 2'b10                    : 2'b01;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        bus_req   = 1'b0;
        bus_wen   = 1'b0;
        bus_mode  = '0;
        bus_num   = '0;
        bus_addr  = '0;
        bus_dat_o = '0;
        m_ready   = 2'b00;
        m_dat_r   = '0;
        grant     = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (|m_req) begin
                    // On a tie the master that was not served last wins;
                    // otherwise m_req[1] alone identifies the single requester.
                    owner_d = (&m_req) ? ~last_q : m_req[1];
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                grant     = own_onehot;
                bus_req   = own_req;
                bus_wen   = own_wen;
                bus_mode  = own_mode;
                bus_num   = own_num;
                bus_addr  = own_addr;
                bus_dat_o = own_dat;
                if (!own_req) begin
                    // Owner withdrew its request: abandon silently.
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else if (bus_ready) begin
                    // Slave acknowledgement beats a watchdog expiry in the same cycle.
                    m_ready = own_onehot;
                    m_dat_r = bus_dat_i;
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else if (cnt_q == CNT_LAST) begin
                    m_ready = own_onehot;
                    m_dat_r = ERR_DATA;
                    bus_req = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout_err = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int XLEN = 32;
    localparam int SW   = 4;
    localparam int AW   = XLEN - SW;
    localparam int TO   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      m_req;
    logic [1:0]      m_wen;
    logic [5:0]      m_mode;
    logic [2*SW-1:0] m_num;
    logic [2*AW-1:0] m_addr;
    logic [63:0]     m_dat_w;
    logic [31:0]     m_dat_r;
    logic [1:0]      m_ready;
    logic            bus_req, bus_wen;
    logic [2:0]      bus_mode;
    logic [SW-1:0]   bus_num;
    logic [AW-1:0]   bus_addr;
    logic [31:0]     bus_dat_o, bus_dat_i;
    logic            bus_ready;
    logic [1:0]      grant;
    logic            timeout_err;

    logic            f_wen  [2];
    logic [2:0]      f_mode [2];
    logic [SW-1:0]   f_num  [2];
    logic [AW-1:0]   f_addr [2];
    logic [31:0]     f_dat  [2];

    assign m_wen   = {f_wen[1], f_wen[0]};
    assign m_mode  = {f_mode[1], f_mode[0]};
    assign m_num   = {f_num[1], f_num[0]};
    assign m_addr  = {f_addr[1], f_addr[0]};
    assign m_dat_w = {f_dat[1], f_dat[0]};

    int checks = 0;
    int errors = 0;
    logic err_exp = 1'b0;
    int   last_m;
    int   pend [2];
    int   w;

    bus_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_wen(m_wen), .m_mode(m_mode), .m_num(m_num),
        .m_addr(m_addr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ready(m_ready),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_mode(bus_mode), .bus_num(bus_num),
        .bus_addr(bus_addr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ready(bus_ready), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields(input int m);
        f_wen[m]  = 1'($urandom_range(0, 1));
        f_mode[m] = 3'($urandom);
        f_num[m]  = SW'($urandom);
        f_addr[m] = AW'($urandom);
        f_dat[m]  = $urandom;
    endtask

    // One arbitration cycle: bus must be quiet; leaves the bench at posedge+1.
    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_bus_req", 32'(bus_req), 32'd0);
        chk("idle_m_ready", 32'(m_ready), 32'd0);
        chk("idle_m_dat_r", m_dat_r, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic start(input logic [1:0] req);
        m_req = req;
        idle_cycle();
    endtask

    // Slave acknowledges on BUSY cycle lat+1; if that is beyond TO the watchdog
    // must end the transaction on BUSY cycle TO with ERR data.
    task automatic serve(input int m, input int lat, input logic [31:0] d);
        int  lim;
        logic normal;
        lim    = (lat + 1 < TO) ? lat + 1 : TO;
        normal = (lat + 1 <= TO);
        for (int k = 1; k <= lim; k++) begin
            bus_ready = (k == lat + 1);
            bus_dat_i = (k == lat + 1) ? d : $urandom;
            @(negedge clk);
            chk("grant", 32'(grant), 32'(1 << m));
            chk("bus_wen", 32'(bus_wen), 32'(f_wen[m]));
            chk("bus_mode", 32'(bus_mode), 32'(f_mode[m]));
            chk("bus_num", 32'(bus_num), 32'(f_num[m]));
            chk("bus_addr", 32'(bus_addr), 32'(f_addr[m]));
            chk("bus_dat_o", bus_dat_o, f_dat[m]);
            chk("timeout_err", 32'(timeout_err), 32'(err_exp));
            if (k == lim) begin
                chk("done_m_ready", 32'(m_ready), 32'(1 << m));
                chk("done_m_dat_r", m_dat_r, normal ? d : ERR);
                chk("done_bus_req", 32'(bus_req), 32'(normal));
                if (!normal) err_exp = 1'b1;
            end else begin
                chk("wait_m_ready", 32'(m_ready), 32'd0);
                chk("wait_m_dat_r", m_dat_r, 32'd0);
                chk("wait_bus_req", 32'(bus_req), 32'd1);
            end
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0; m_req = 2'b00; bus_ready = 1'b0; bus_dat_i = 32'h0;
        rand_fields(0); rand_fields(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_num", 32'(bus_num), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_dat_r", m_dat_r, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Both request from reset: 0, then 1, then 0 again although 0 re-requested.
        start(2'b11);
        serve(0, 1, $urandom);
        rand_fields(0);
        idle_cycle();
        serve(1, 0, $urandom);
        m_req[1] = 1'b0;
        idle_cycle();
        serve(0, 2, $urandom);
        m_req = 2'b00;

        // Single master 0 read.
        f_num[0] = 4'd1; f_addr[0] = 28'h100; f_wen[0] = 1'b0;
        start(2'b01);
        serve(0, 3, 32'h1234_5678);
        m_req = 2'b00;
        idle_cycle();

        // Slave ready in the same cycle the watchdog would expire.
        rand_fields(1);
        start(2'b10);
        serve(1, TO - 1, 32'hA5A5_0001);
        m_req = 2'b00;
        idle_cycle();
        chk("no_err_on_tie", 32'(timeout_err), 32'd0);

        // Master 1 write that the slave never acknowledges.
        f_wen[1] = 1'b1; f_dat[1] = 32'hCAFE_F00D;
        start(2'b10);
        serve(1, 100, 32'h0);
        m_req = 2'b00;
        idle_cycle();
        chk("err_sticky_1", 32'(timeout_err), 32'd1);
        idle_cycle();
        chk("err_sticky_2", 32'(timeout_err), 32'd1);

        // Asynchronous reset in the middle of a master 0 transaction.
        start(2'b01);
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant), 32'd1);
        chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_bus_req", 32'(bus_req), 32'd0);
        chk("async_bus_addr", 32'(bus_addr), 32'd0);
        chk("async_bus_dat_o", bus_dat_o, 32'd0);
        chk("async_m_ready", 32'(m_ready), 32'd0);
        chk("async_timeout_err", 32'(timeout_err), 32'd0);
        err_exp = 1'b0;
        m_req = 2'b10;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycle();
        serve(1, 2, $urandom);
        m_req = 2'b00;
        idle_cycle();

        // Master 0 abandons its request; master 1 waiting is served next.
        start(2'b11);
        @(negedge clk);
        chk("abort_grant", 32'(grant), 32'd1);
        @(posedge clk); #1;
        m_req = 2'b10;
        @(negedge clk);
        chk("abort_m_ready", 32'(m_ready), 32'd0);
        chk("abort_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        idle_cycle();
        serve(1, 1, $urandom);
        m_req = 2'b00;
        bus_ready = 1'b1; bus_dat_i = 32'h5555_AAAA;
        idle_cycle();
        bus_ready = 1'b0;
        idle_cycle();
        last_m = 1;

        // Random traffic: round-robin order, latencies and watchdog outcome
        // predicted from the transaction-level rules.
        pend[0] = $urandom_range(4, 10);
        pend[1] = $urandom_range(4, 10);
        rand_fields(0); rand_fields(1);
        m_req = 2'b11;
        while (pend[0] + pend[1] > 0) begin
            idle_cycle();
            w = (pend[0] > 0 && pend[1] > 0) ? 1 - last_m : ((pend[0] > 0) ? 0 : 1);
            serve(w, $urandom_range(0, 10), $urandom);
            last_m = w;
            pend[w]--;
            if (pend[w] == 0) m_req[w] = 1'b0;
            else rand_fields(w);
        end
        idle_cycle();
        chk("final_timeout_err", 32'(timeout_err), 32'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
